multdiv_issuer: RTL and testbench
=================================

Name: multdiv_issuer

Overview:
- Pipeline-side initiator for the shared multiply/divide unit; the unit is the responder.
- Accepts one mult/div request from execute and registers the operands.
- Holds ctrl_MULT or ctrl_DIV high for the whole operation, waits for data_resultRDY, then captures the result and exception.
- Stalls the pipeline while busy, and pulses a single-cycle writeback; adds flush and a hang timeout.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before a forced exception writeback; must be >= 2.
- CNT_W, 7, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  execute stage presents a mult/div op.
- req_op  in  1  0 = multiply, 1 = divide.
- req_a  in  32  operand A.
- req_b  in  16  operand B.
- req_rd  in  5  destination register tag.
- flush  in  1  abort any in-flight op, no writeback.
- data_operandA  out  32  registered operand A to the unit.
- data_operandB  out  16  registered operand B to the unit.
- ctrl_MULT  out  1  multiply select, held for the whole op.
- ctrl_DIV  out  1  divide select, held for the whole op.
- data_result  in  32  unit result; valid only while ctrl held.
- data_exception  in  1  unit exception (overflow / divide-by-zero).
- data_inputRDY  in  1  unit ready (informational; sampled for the status bit).
- data_resultRDY  in  1  unit result valid.
- stall  out  1  freeze upstream pipeline.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_data  out  32  captured result.
- wb_rd  out  5  captured tag.
- wb_exception  out  1  captured exception or timeout.
- timeout  out  1  one-cycle pulse, concurrent with wb_valid, when the timeout fired.

Behaviour:
- Reset:
  - state = IDLE.
  - ctrl_MULT = ctrl_DIV = 0.
  - Operands, wb_data and wb_rd = 0.
  - wb_valid, wb_exception, timeout = 0.
  - Wait counter = 0.
  - Reset mid-operation drops the op silently; the unit sees ctrl fall immediately.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> GAP -> IDLE.
- IDLE:
  - If req_valid & ~flush: latch req_a, req_b, req_op and req_rd; go to ISSUE.
- ISSUE:
  - Exactly one of ctrl_MULT / ctrl_DIV is high, per the latched op.
  - Clear the counter; go to WAIT.
- WAIT:
  - ctrl is held high and the operands are held stable.
  - On data_resultRDY=1: latch data_result into wb_data and data_exception into wb_exception; go to DONE.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no resultRDY: wb_data = 0, wb_exception = 1, set the timeout flag; go to DONE.
- DONE:
  - wb_valid = 1 for exactly this cycle; timeout = 1 if the flag is set.
  - ctrl drops to 0.
  - Go to GAP.
- GAP:
  - One cycle with ctrl low, guaranteeing the unit sees a low level between ops.
  - Go to IDLE.
  - A new request cannot be accepted earlier than the cycle after GAP.
- stall (combinational):
  - 1 when (IDLE & req_valid & ~flush), or in ISSUE or WAIT.
  - 0 in DONE, GAP and idle-without-request.
  - The upstream request is therefore frozen until writeback; the pipeline advances in the DONE cycle.
- ctrl_MULT and ctrl_DIV are registered and never both high.
- Latency:
  - Result-to-writeback is 1 cycle: resultRDY sampled at edge N gives wb_valid during cycle N+1.
  - Minimum request-to-wb_valid is 3 cycles.
- flush:
  - In ISSUE or WAIT: go to GAP with ctrl low; no wb_valid.
  - In DONE: the writeback still completes; flush has no effect there.
  - Same cycle as a request in IDLE: the request is ignored.
- resultRDY and timeout expiring in the same cycle: the result wins; no timeout.
- data_result and data_exception are sampled only in WAIT; their values in all other states are ignored, since they may be Z/0.
- data_inputRDY is unused for control and may be left unconnected in synthesis.

Decomposition:
- Shared package multdiv_pkg:
  - State encoding constants: IDLE, ISSUE, WAIT, DONE, GAP (3-bit).
  - OP_MULT = 0, OP_DIV = 1.
- Optional sub-module multdiv_wait_timer: counter with clear, enable and expired flag. Everything else stays in a single module.

Test Plan:
- Mult, unit model latency 32: req_a = 7, req_b = 6, rd = 5.
  - ctrl_MULT stays high 33 cycles, stall high throughout, then wb_valid one cycle.
  - wb_data = 42, wb_rd = 5, wb_exception = 0; ctrl low for at least 1 cycle before the next op.
- Divide by zero: req_op = 1, a = 100, b = 0, model asserts exception.
  - wb_exception = 1, timeout = 0, ctrl_DIV only.
- Hang: model never asserts resultRDY, TIMEOUT_CYCLES = 64.
  - wb_valid with wb_exception = 1, timeout = 1 and wb_data = 0 at the cycle count given by the Behaviour rules.
  - Check that count exactly.
- Flush in WAIT at cycle 10: ctrl falls next cycle, no wb_valid, and stall falls.
  - A back-to-back request is accepted 2 cycles after the flush.
- Asynchronous reset asserted mid-WAIT, between clock edges: ctrl and stall go to 0 immediately and no wb_valid occurs.
  - After deassert, mult 0xFFFF x 0x0002 completes with wb_data = 0x1FFFE.
- resultRDY on the same edge as timeout expiry: result captured, timeout = 0.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared encodings for the multiply/divide issuer and its wait timer.
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_wait_timer.sv
// Wait counter for the issuer: cleared on issue, counts stalled WAIT cycles,
// flags when the last permitted WAIT cycle is reached.
module multdiv_wait_timer
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issuer.sv
// Pipeline-side initiator for the shared mult/div unit. Latches one request,
// holds the op select high until the unit answers (or the wait times out),
// then pulses a one-cycle writeback and leaves a low gap before the next op.
module multdiv_issuer
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [15:0] req_b,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic [31:0] data_operandA,
    output logic [15:0] data_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_inputRDY,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_exception,
    output logic        timeout
);

    state_e      state_q, state_d;
    logic        op_q, op_d;
    logic [31:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_exc_q, wb_exc_d;
    logic        timeout_q, timeout_d;
    logic        tmr_expired;

    // Unit-ready is informational only; it does not steer control.
    logic unused_inputs;
    assign unused_inputs = data_inputRDY;

    multdiv_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (state_q == ISSUE),
        .en     ((state_q == WAIT) && !data_resultRDY && !tmr_expired),
        .expired(tmr_expired)
    );

    // Next-state, operand capture and writeback capture.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_exc_d   = wb_exc_q;
        wb_valid_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_d    = req_op;
                    opa_d   = req_a;
                    opb_d   = req_b;
                    rd_d    = req_rd;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = flush ? GAP : WAIT;
            WAIT: begin
                if (flush) begin
                    state_d = GAP;
                end else if (data_resultRDY) begin
                    // A result on the expiry cycle still wins over the timeout.
                    wb_data_d  = data_result;
                    wb_exc_d   = data_exception;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    state_d    = DONE;
                end else if (tmr_expired) begin
                    wb_data_d  = '0;
                    wb_exc_d   = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_valid_d = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Select is registered off the next state so it is high exactly in ISSUE/WAIT.
        ctrl_mult_d = ((state_d == ISSUE) || (state_d == WAIT)) && (op_d == OP_MULT);
        ctrl_div_d  = ((state_d == ISSUE) || (state_d == WAIT)) && (op_d == OP_DIV);
    end

    // State and datapath registers; reset drops any op and lowers ctrl at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_MULT;
            opa_q       <= '0;
            opb_q       <= '0;
            rd_q        <= '0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_exc_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rd_q        <= rd_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_exc_q    <= wb_exc_d;
            timeout_q   <= timeout_d;
        end
    end

    // Upstream freezes from acceptance until the writeback cycle.
    always_comb begin
        stall = ((state_q == IDLE) && req_valid && !flush) ||
                (state_q == ISSUE) || (state_q == WAIT);
    end

    assign data_operandA = opa_q;
    assign data_operandB = opb_q;
    assign ctrl_MULT     = ctrl_mult_q;
    assign ctrl_DIV      = ctrl_div_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_exception  = wb_exc_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_multdiv_issuer.sv
// Bench for multdiv_issuer: a responder model answers after a chosen number of
// select-high cycles; expected writeback timing/values come from the op rules.
module tb_multdiv_issuer;

    localparam int T = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_op, flush;
    logic [31:0] req_a;
    logic [15:0] req_b;
    logic [4:0]  req_rd;
    logic [31:0] data_operandA;
    logic [15:0] data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_inputRDY, data_resultRDY;
    logic        stall, wb_valid, wb_exception, timeout;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;

    int total = 0;
    int bad   = 0;
    int hi    = 0;

    multdiv_issuer #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .req_rd(req_rd), .flush(flush),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_exception(data_exception),
        .data_inputRDY(data_inputRDY), .data_resultRDY(data_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_exception(wb_exception), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // What the arithmetic unit would return for an op.
    function automatic void unit_ref(input logic op, input logic [31:0] a, input logic [15:0] b,
                                     output logic [31:0] res, output logic exc);
        logic [47:0] p;
        if (op == 1'b0) begin
            p   = {16'h0, a} * {32'h0, b};
            res = p[31:0];
            exc = |p[47:32];
        end else if (b == 16'h0) begin
            res = 32'h0;
            exc = 1'b1;
        end else begin
            res = a / {16'h0, b};
            exc = 1'b0;
        end
    endfunction

    // Responder: answers in the (lat+1)-th consecutive select-high cycle;
    // drives junk on the result bus otherwise.
    task automatic unit_drive(input int lat, input logic [31:0] res, input logic exc);
        if (ctrl_MULT || ctrl_DIV) hi++; else hi = 0;
        if (hi == lat + 1) begin
            data_resultRDY = 1'b1;
            data_result    = res;
            data_exception = exc;
        end else begin
            data_resultRDY = 1'b0;
            data_result    = $urandom;
            data_exception = 1'($urandom_range(0, 1));
        end
    endtask

    // abort_kind: 0 none, 1 flush at abort_cyc, 2 async reset at abort_cyc.
    task automatic run_op(input logic op, input logic [31:0] a, input logic [15:0] b,
                          input logic [4:0] rd, input int lat, input int abort_cyc,
                          input int abort_kind);
        logic [31:0] res;
        logic        exc;
        int          exp_cyc;
        int          cyc;
        bit          got;
        unit_ref(op, a, b, res, exc);
        exp_cyc = (lat <= T) ? lat + 2 : T + 2;
        @(negedge clock);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        data_resultRDY = 1'b0; hi = 0;
        #1 chk("stall_req", 48'(stall), 48'd1);
        got = 1'b0;
        for (cyc = 1; cyc <= T + 10; cyc++) begin
            @(negedge clock);
            req_valid = 1'b0; req_a = $urandom; req_b = 16'($urandom); req_rd = 5'($urandom);
            if (wb_valid) begin
                got = 1'b1;
                break;
            end
            chk("ctrl_held", 48'({ctrl_MULT, ctrl_DIV}), op ? 48'd1 : 48'd2);
            chk("stall_busy", 48'(stall), 48'd1);
            chk("opA_held", 48'(data_operandA), 48'(a));
            chk("opB_held", 48'(data_operandB), 48'(b));
            if (cyc == abort_cyc && abort_kind == 1) begin
                flush = 1'b1;
                unit_drive(lat, res, exc);
                @(negedge clock);
                flush = 1'b0;
                chk("flush_ctrl", 48'({ctrl_MULT, ctrl_DIV}), 48'd0);
                chk("flush_stall", 48'(stall), 48'd0);
                chk("flush_wb", 48'(wb_valid), 48'd0);
                return;
            end
            if (cyc == abort_cyc && abort_kind == 2) begin
                #2 reset = 1'b1;
                #1 chk("rst_ctrl", 48'({ctrl_MULT, ctrl_DIV}), 48'd0);
                chk("rst_stall", 48'(stall), 48'd0);
                @(negedge clock);
                chk("rst_wb", 48'(wb_valid), 48'd0);
                reset = 1'b0;
                @(negedge clock);
                chk("rst_wb_after", 48'(wb_valid), 48'd0);
                chk("rst_ctrl_after", 48'({ctrl_MULT, ctrl_DIV}), 48'd0);
                return;
            end
            unit_drive(lat, res, exc);
        end
        chk("wb_seen", 48'(got), 48'd1);
        chk("wb_cycle", 48'(cyc), 48'(exp_cyc));
        chk("wb_data", 48'(wb_data), (lat <= T) ? 48'(res) : 48'd0);
        chk("wb_rd", 48'(wb_rd), 48'(rd));
        chk("wb_exc", 48'(wb_exception), (lat <= T) ? 48'(exc) : 48'd1);
        chk("timeout", 48'(timeout), (lat <= T) ? 48'd0 : 48'd1);
        chk("done_ctrl", 48'({ctrl_MULT, ctrl_DIV}), 48'd0);
        chk("done_stall", 48'(stall), 48'd0);
        // A request offered in DONE/GAP must not be taken.
        req_valid = 1'b1;
        unit_drive(lat, res, exc);
        @(negedge clock);
        chk("gap_wb", 48'(wb_valid), 48'd0);
        chk("gap_timeout", 48'(timeout), 48'd0);
        chk("gap_ctrl", 48'({ctrl_MULT, ctrl_DIV}), 48'd0);
        chk("gap_stall", 48'(stall), 48'd0);
        req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
        flush = 1'b0; data_result = '0; data_exception = 1'b0; data_inputRDY = 1'b1;
        data_resultRDY = 1'b0;
        #12;
        chk("rst_ctrl0", 48'({ctrl_MULT, ctrl_DIV}), 48'd0);
        chk("rst_wbv0", 48'({wb_valid, wb_exception, timeout, stall}), 48'd0);
        chk("rst_wbdata0", 48'(wb_data), 48'd0);
        chk("rst_wbrd0", 48'(wb_rd), 48'd0);
        chk("rst_opA0", 48'(data_operandA), 48'd0);
        chk("rst_opB0", 48'(data_operandB), 48'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op(1'b0, 32'd7, 16'd6, 5'd5, 32, 0, 0);          // basic multiply
        run_op(1'b1, 32'd100, 16'd0, 5'd9, 5, 0, 0);         // divide by zero
        run_op(1'b0, 32'h1234, 16'h55, 5'd3, 1000, 0, 0);    // hang -> timeout
        run_op(1'b1, 32'd999, 16'd10, 5'd2, T, 0, 0);        // result on expiry edge
        run_op(1'b0, 32'd3, 16'd3, 5'd4, T + 1, 0, 0);       // one past expiry
        run_op(1'b1, 32'd77, 16'd7, 5'd31, 1, 0, 0);         // minimum latency
        run_op(1'b1, 32'd1000, 16'd7, 5'd6, 40, 10, 1);      // flush in WAIT
        run_op(1'b0, 32'd11, 16'd12, 5'd1, 3, 0, 0);         // back-to-back after flush

        // Request together with flush in IDLE is ignored.
        @(negedge clock);
        req_valid = 1'b1; flush = 1'b1; req_op = 1'b0;
        #1 chk("idle_flush_stall", 48'(stall), 48'd0);
        @(negedge clock);
        chk("idle_flush_ctrl", 48'({ctrl_MULT, ctrl_DIV}), 48'd0);
        req_valid = 1'b0; flush = 1'b0;

        run_op(1'b1, 32'd5000, 16'd3, 5'd8, 50, 12, 2);      // async reset mid-WAIT
        run_op(1'b0, 32'hFFFF, 16'h0002, 5'd7, 4, 0, 0);     // 0x1FFFE after reset

        for (int i = 0; i < 10; i++) begin
            logic [15:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            run_op(1'($urandom_range(0, 1)), $urandom, rb, 5'($urandom),
                   int'($urandom_range(1, T + 3)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
